mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single data-memory port between the instruction-fetch unit (IF, read-only) and the load/store unit (LSU, read/write). It sits between the core pipeline and the memory port (DPI bridge or bus adapter). It sequences one outstanding transaction at a time through an IDLE/REQ/WAIT/RESP state machine and routes each response back to the requester that issued it.

---
 rtl/mem_arbiter_pkg.sv | 33 +++
 rtl/mem_arbiter_arb_pick.sv | 47 ++++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared constants for the two-requester memory arbiter:
//   - FSM state encodings (2 bits)
//   - owner IDs recorded at acceptance (IF = 0, LSU = 1)
//   - default datapath width
//   - grant-vector bit positions and a grant-to-owner helper
// Optional feature macro used by the arbiter files: MEM_ARB_RR_EN
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int XLEN_DEF = 64;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_RESP = 2'd3
  } arb_state_e;

  localparam logic ARB_OWN_IF  = 1'b0;
  localparam logic ARB_OWN_LSU = 1'b1;

  // Bit positions inside the one-hot grant vector
  localparam int GNT_IF  = 0;
  localparam int GNT_LSU = 1;

  // Map a one-hot grant to the owner ID that is recorded at acceptance
  function automatic logic gnt_owner(input logic [1:0] gnt);
    return (gnt[GNT_LSU] && !gnt[GNT_IF]) ? ARB_OWN_LSU : ARB_OWN_IF;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational 2-way picker producing a one-hot grant.
// Macro MEM_ARB_RR_EN:
//   defined   - on contention grant the requester that was not granted last
//               (i_last_own port exists only in this build)
//   undefined - fixed priority, LSU over IF
// Ports:
//   i_if_valid   IF request valid
//   i_lsu_valid  LSU request valid
//   i_last_own   owner of the previous grant (round-robin build only)
//   o_grant      one-hot grant, bit GNT_IF / GNT_LSU
// -----------------------------------------------------------------------------
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       i_if_valid,
  input  logic       i_lsu_valid,
`ifdef MEM_ARB_RR_EN
  input  logic       i_last_own,
`endif
  output logic [1:0] o_grant
);

  // Grant selection; only the contended case depends on the build option
  always_comb begin
    o_grant = 2'b00;
    if (i_lsu_valid && i_if_valid) begin
`ifdef MEM_ARB_RR_EN
      if (i_last_own == ARB_OWN_LSU) begin
        o_grant[GNT_IF] = 1'b1;
      end else begin
        o_grant[GNT_LSU] = 1'b1;
      end
`else
      o_grant[GNT_LSU] = 1'b1;
`endif
    end else if (i_lsu_valid) begin
      o_grant[GNT_LSU] = 1'b1;
    end else if (i_if_valid) begin
      o_grant[GNT_IF] = 1'b1;
    end else begin
      o_grant = 2'b00;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between instruction fetch (read-only) and the LSU.
// One transaction at a time: IDLE (arbitrate/accept) -> REQ (hold request
// until mem ready) -> WAIT (until mem response) -> RESP (one-cycle strobe to
// the owner) -> IDLE.
// Macro MEM_ARB_RR_EN: round-robin arbitration on contention (default build:
// fixed priority LSU over IF, no pointer register).
// Ports:
//   clk, rst                      clock, async active-high reset
//   if_*                          IF request/ready, response strobe and data
//   lsu_*                         LSU request (we/addr/wdata/mask)/ready,
//                                 response strobe and data (0 for stores)
//   mem_*                         memory request/ready, response/data
//   busy_o                        registered, high whenever not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int MASK_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid_i,
  input  logic [XLEN-1:0]   if_addr_i,
  output logic              if_req_ready_o,
  output logic              if_resp_valid_o,
  output logic [XLEN-1:0]   if_rdata_o,
  input  logic              lsu_req_valid_i,
  input  logic              lsu_we_i,
  input  logic [XLEN-1:0]   lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  input  logic [MASK_W-1:0] lsu_mask_i,
  output logic              lsu_req_ready_o,
  output logic              lsu_resp_valid_o,
  output logic [XLEN-1:0]   lsu_rdata_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [MASK_W-1:0] mem_mask_o,
  input  logic              mem_resp_valid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              busy_o
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_busy;
  logic              r_owner;
  logic              r_we;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [MASK_W-1:0] r_mask;
  logic [XLEN-1:0]   r_rdata;
  logic [1:0]        w_grant;
  logic              w_accept;
`ifdef MEM_ARB_RR_EN
  logic              r_last_own;
`endif

  arb_pick u_pick (
    .i_if_valid  (if_req_valid_i),
    .i_lsu_valid (lsu_req_valid_i),
`ifdef MEM_ARB_RR_EN
    .i_last_own  (r_last_own),
`endif
    .o_grant     (w_grant)
  );

  // State register; busy is registered from the next state so it tracks r_state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ARB_IDLE);
    end
  end

  // Next-state logic and combinational accept/ready in IDLE
  always_comb begin
    w_state_nxt     = r_state;
    w_accept        = 1'b0;
    if_req_ready_o  = 1'b0;
    lsu_req_ready_o = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant != 2'b00) begin
          w_accept        = 1'b1;
          if_req_ready_o  = w_grant[GNT_IF];
          lsu_req_ready_o = w_grant[GNT_LSU];
          w_state_nxt     = ARB_REQ;
        end else begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_REQ: begin
        if (mem_req_ready_i) begin
          w_state_nxt = ARB_WAIT;
        end else begin
          w_state_nxt = ARB_REQ;
        end
      end
      ARB_WAIT: begin
        if (mem_resp_valid_i) begin
          w_state_nxt = ARB_RESP;
        end else begin
          w_state_nxt = ARB_WAIT;
        end
      end
      ARB_RESP: w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  // Request latch: captured only at acceptance; IF reads use we=0, full mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= ARB_OWN_IF;
      r_we    <= 1'b0;
      r_addr  <= {XLEN{1'b0}};
      r_wdata <= {XLEN{1'b0}};
      r_mask  <= {MASK_W{1'b0}};
    end else if (w_accept) begin
      r_owner <= gnt_owner(w_grant);
      if (w_grant[GNT_LSU]) begin
        r_we    <= lsu_we_i;
        r_addr  <= lsu_addr_i;
        r_wdata <= lsu_wdata_i;
        r_mask  <= lsu_mask_i;
      end else begin
        r_we    <= 1'b0;
        r_addr  <= if_addr_i;
        r_wdata <= {XLEN{1'b0}};
        r_mask  <= {MASK_W{1'b1}};
      end
    end
  end

  // Response data latch; stores return zero, responses outside WAIT are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= {XLEN{1'b0}};
    end else if ((r_state == ARB_WAIT) && mem_resp_valid_i) begin
      r_rdata <= r_we ? {XLEN{1'b0}} : mem_rdata_i;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin pointer: starts IF-last so LSU is favoured first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_own <= ARB_OWN_IF;
    end else if (w_accept) begin
      r_last_own <= gnt_owner(w_grant);
    end
  end
`endif

  assign mem_req_valid_o  = (r_state == ARB_REQ);
  assign mem_we_o         = r_we;
  assign mem_addr_o       = r_addr;
  assign mem_wdata_o      = r_wdata;
  assign mem_mask_o       = r_mask;
  assign if_resp_valid_o  = (r_state == ARB_RESP) && (r_owner == ARB_OWN_IF);
  assign lsu_resp_valid_o = (r_state == ARB_RESP) && (r_owner == ARB_OWN_LSU);
  assign if_rdata_o       = r_rdata;
  assign lsu_rdata_o      = r_rdata;
  assign busy_o           = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A transaction-level reference model
// (who wins arbitration, what the memory port must show, what the owner gets
// back and on which cycle) drives the expectations.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int XLEN   = 64;
  localparam int MASK_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_valid_i;
  logic [XLEN-1:0]   if_addr_i;
  logic              if_req_ready_o;
  logic              if_resp_valid_o;
  logic [XLEN-1:0]   if_rdata_o;
  logic              lsu_req_valid_i;
  logic              lsu_we_i;
  logic [XLEN-1:0]   lsu_addr_i;
  logic [XLEN-1:0]   lsu_wdata_i;
  logic [MASK_W-1:0] lsu_mask_i;
  logic              lsu_req_ready_o;
  logic              lsu_resp_valid_o;
  logic [XLEN-1:0]   lsu_rdata_o;
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic              mem_we_o;
  logic [XLEN-1:0]   mem_addr_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic [MASK_W-1:0] mem_mask_o;
  logic              mem_resp_valid_i;
  logic [XLEN-1:0]   mem_rdata_i;
  logic              busy_o;

  int checks = 0;
  int errors = 0;
  bit m_last_lsu;  // model: previous grant went to the LSU

  mem_arbiter #(.XLEN(XLEN), .MASK_W(MASK_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_req_valid_i   (if_req_valid_i),
    .if_addr_i        (if_addr_i),
    .if_req_ready_o   (if_req_ready_o),
    .if_resp_valid_o  (if_resp_valid_o),
    .if_rdata_o       (if_rdata_o),
    .lsu_req_valid_i  (lsu_req_valid_i),
    .lsu_we_i         (lsu_we_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_wdata_i      (lsu_wdata_i),
    .lsu_mask_i       (lsu_mask_i),
    .lsu_req_ready_o  (lsu_req_ready_o),
    .lsu_resp_valid_o (lsu_resp_valid_o),
    .lsu_rdata_o      (lsu_rdata_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_mask_o       (mem_mask_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_rdata_i      (mem_rdata_i),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Arbitration rule from the requester's point of view
  function automatic bit model_lsu_wins(input bit ifv, input bit lsuv);
    if (ifv && lsuv) begin
`ifdef MEM_ARB_RR_EN
      return !m_last_lsu;
`else
      return 1'b1;
`endif
    end
    return lsuv;
  endfunction

  task automatic apply_reset();
    rst              = 1'b1;
    if_req_valid_i   = 1'b0;
    if_addr_i        = 64'h0;
    lsu_req_valid_i  = 1'b0;
    lsu_we_i         = 1'b0;
    lsu_addr_i       = 64'h0;
    lsu_wdata_i      = 64'h0;
    lsu_mask_i       = 8'h00;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_rdata_i      = 64'h0;
    next_cyc();
    next_cyc();
    rst        = 1'b0;
    m_last_lsu = 1'b0;
  endtask

  // One full transaction starting in IDLE: accept, rdly stalled REQ cycles,
  // pdly idle WAIT cycles, RESP. Returns the grant observed at the DUT.
  task automatic do_txn(input bit ifv, input bit lsuv, input logic [63:0] ia,
                        input logic [63:0] la, input bit we, input logic [63:0] wd,
                        input logic [7:0] mk, input logic [63:0] alt_addr,
                        input int rdly, input int pdly, input logic [63:0] rd,
                        input bit spur, output bit lsu_won);
    bit lw;
    bit ewe;
    logic [63:0] ea, ewd, erd, got;
    logic [7:0]  emk;
    lw  = model_lsu_wins(ifv, lsuv);
    ea  = lw ? la : ia;
    ewe = lw ? we : 1'b0;
    ewd = lw ? wd : 64'h0;
    emk = lw ? mk : 8'hFF;
    erd = ewe ? 64'h0 : rd;
    if_req_valid_i  = ifv;
    if_addr_i       = ia;
    lsu_req_valid_i = lsuv;
    lsu_we_i        = we;
    lsu_addr_i      = la;
    lsu_wdata_i     = wd;
    lsu_mask_i      = mk;
    sample();
    lsu_won = lsu_req_ready_o;
    checks++;
    if (if_req_ready_o !== (ifv && !lw) || lsu_req_ready_o !== lw || busy_o !== 1'b0 ||
        if_resp_valid_o !== 1'b0 || lsu_resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL accept: if_rdy=%b lsu_rdy=%b busy=%b strobes=%b%b, expected if_rdy=%b lsu_rdy=%b busy=0 strobes=00",
               if_req_ready_o, lsu_req_ready_o, busy_o, if_resp_valid_o, lsu_resp_valid_o,
               ifv && !lw, lw);
    end
    m_last_lsu = lw;
    next_cyc();
    // Winner drops its request; inputs are scrambled to prove the latch holds
    if (lw) lsu_req_valid_i = 1'b0;
    else    if_req_valid_i  = 1'b0;
    if_addr_i   = alt_addr;
    lsu_addr_i  = alt_addr;
    lsu_wdata_i = ~wd;
    lsu_mask_i  = ~mk;
    lsu_we_i    = ~we;
    for (int j = 0; j <= rdly; j++) begin
      mem_req_ready_i  = (j == rdly);
      mem_resp_valid_i = spur && (j == 0);
      mem_rdata_i      = ~rd;
      sample();
      checks++;
      if (mem_req_valid_o !== 1'b1 || busy_o !== 1'b1 || mem_addr_o !== ea ||
          mem_we_o !== ewe || mem_wdata_o !== ewd || mem_mask_o !== emk ||
          if_req_ready_o !== 1'b0 || lsu_req_ready_o !== 1'b0 ||
          if_resp_valid_o !== 1'b0 || lsu_resp_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL req[%0d]: vld=%b busy=%b addr=%h we=%b wdata=%h mask=%h rdy=%b%b str=%b%b, expected vld=1 busy=1 addr=%h we=%b wdata=%h mask=%h rdy=00 str=00",
                 j, mem_req_valid_o, busy_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_mask_o,
                 if_req_ready_o, lsu_req_ready_o, if_resp_valid_o, lsu_resp_valid_o,
                 ea, ewe, ewd, emk);
      end
      next_cyc();
    end
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    for (int j = 0; j <= pdly; j++) begin
      mem_resp_valid_i = (j == pdly);
      mem_rdata_i      = (j == pdly) ? rd : ~rd;
      sample();
      checks++;
      if (mem_req_valid_o !== 1'b0 || busy_o !== 1'b1 ||
          if_resp_valid_o !== 1'b0 || lsu_resp_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL wait[%0d]: vld=%b busy=%b str=%b%b, expected vld=0 busy=1 str=00",
                 j, mem_req_valid_o, busy_o, if_resp_valid_o, lsu_resp_valid_o);
      end
      next_cyc();
    end
    mem_resp_valid_i = 1'b0;
    mem_rdata_i      = ~rd;
    sample();
    got = lw ? lsu_rdata_o : if_rdata_o;
    checks++;
    if (if_resp_valid_o !== !lw || lsu_resp_valid_o !== lw || got !== erd || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL resp: if_str=%b lsu_str=%b rdata=%h busy=%b, expected if_str=%b lsu_str=%b rdata=%h busy=1",
               if_resp_valid_o, lsu_resp_valid_o, got, busy_o, !lw, lw, erd);
    end
    next_cyc();
  endtask

  task automatic test_reset();
    apply_reset();
    sample();
    checks++;
    if (busy_o !== 1'b0 || mem_req_valid_o !== 1'b0 || if_req_ready_o !== 1'b0 ||
        lsu_req_ready_o !== 1'b0 || if_resp_valid_o !== 1'b0 || lsu_resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b mvld=%b rdy=%b%b str=%b%b, expected all 0",
               busy_o, mem_req_valid_o, if_req_ready_o, lsu_req_ready_o, if_resp_valid_o, lsu_resp_valid_o);
    end
    checks++;
    if (mem_addr_o !== 64'h0 || mem_wdata_o !== 64'h0 || mem_mask_o !== 8'h00 ||
        mem_we_o !== 1'b0 || if_rdata_o !== 64'h0 || lsu_rdata_o !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h mask=%h we=%b rdata=%h/%h, expected all 0",
               mem_addr_o, mem_wdata_o, mem_mask_o, mem_we_o, if_rdata_o, lsu_rdata_o);
    end
    next_cyc();
  endtask

  task automatic test_if_alone();
    bit w;
    do_txn(1'b1, 1'b0, 64'h8000_0000, 64'h0, 1'b0, 64'h0, 8'h00, 64'h8000_0040,
           0, 0, 64'h0000_0013, 1'b0, w);
  endtask

  task automatic test_lsu_store();
    bit w;
    do_txn(1'b0, 1'b1, 64'h0, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 64'h8000_2000,
           3, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
  endtask

  task automatic test_contention();
    bit w;
    bit exp_lsu [4];
`ifdef MEM_ARB_RR_EN
    exp_lsu = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_lsu = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    apply_reset();
    for (int t = 0; t < 4; t++) begin
      do_txn(1'b1, 1'b1, 64'h100 + 64'(t), 64'h200 + 64'(t), 1'b0, 64'h0, 8'hF0,
             64'h300, 0, 0, 64'h1000 + 64'(t), 1'b0, w);
      checks++;
      if (w !== exp_lsu[t]) begin
        errors++;
        $display("FAIL contention[%0d]: lsu_granted=%b, expected %b", t, w, exp_lsu[t]);
      end
    end
    if_req_valid_i  = 1'b0;
    lsu_req_valid_i = 1'b0;
    apply_reset();
  endtask

  task automatic test_spurious();
    bit w;
    mem_resp_valid_i = 1'b1;
    mem_rdata_i      = 64'hBAD;
    sample();
    next_cyc();
    mem_resp_valid_i = 1'b0;
    sample();
    checks++;
    if (busy_o !== 1'b0 || mem_req_valid_o !== 1'b0 ||
        if_resp_valid_o !== 1'b0 || lsu_resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL spurious_idle: busy=%b mvld=%b str=%b%b, expected all 0",
               busy_o, mem_req_valid_o, if_resp_valid_o, lsu_resp_valid_o);
    end
    next_cyc();
    do_txn(1'b0, 1'b1, 64'h0, 64'h4000, 1'b0, 64'h55, 8'h3C, 64'h4444,
           2, 0, 64'hCAFE_F00D, 1'b1, w);
  endtask

  task automatic test_reset_mid();
    bit w;
    if_req_valid_i = 1'b1;
    if_addr_i      = 64'h7000;
    sample();
    next_cyc();
    if_req_valid_i  = 1'b0;
    mem_req_ready_i = 1'b1;
    sample();
    next_cyc();
    mem_req_ready_i = 1'b0;
    sample();
    checks++;
    if (busy_o !== 1'b1 || mem_req_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL pre_abort: busy=%b mvld=%b, expected busy=1 mvld=0", busy_o, mem_req_valid_o);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || mem_req_valid_o !== 1'b0 || mem_addr_o !== 64'h0 ||
        mem_mask_o !== 8'h00 || if_resp_valid_o !== 1'b0 || lsu_resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b mvld=%b addr=%h mask=%h str=%b%b, expected all 0",
               busy_o, mem_req_valid_o, mem_addr_o, mem_mask_o, if_resp_valid_o, lsu_resp_valid_o);
    end
    next_cyc();
    rst              = 1'b0;
    m_last_lsu       = 1'b0;
    mem_resp_valid_i = 1'b1;
    mem_rdata_i      = 64'h1234;
    for (int j = 0; j < 2; j++) begin
      sample();
      checks++;
      if (if_resp_valid_o !== 1'b0 || lsu_resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL aborted_resp[%0d]: str=%b%b busy=%b, expected 00 and busy=0",
                 j, if_resp_valid_o, lsu_resp_valid_o, busy_o);
      end
      next_cyc();
      mem_resp_valid_i = 1'b0;
    end
    do_txn(1'b0, 1'b1, 64'h0, 64'h9000, 1'b0, 64'h0, 8'hFF, 64'h9100,
           1, 2, 64'h0BAD_CAFE, 1'b0, w);
  endtask

  task automatic test_input_change();
    bit w;
    do_txn(1'b1, 1'b0, 64'h10, 64'h0, 1'b0, 64'h0, 8'h00, 64'h20,
           2, 1, 64'h77, 1'b0, w);
  endtask

  task automatic test_random(input int n);
    bit w;
    logic [1:0] r;
    for (int t = 0; t < n; t++) begin
      r = 2'($urandom_range(1, 3));
      do_txn(r[0], r[1], {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
             {$urandom, $urandom}, 8'($urandom), {$urandom, $urandom},
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             {$urandom, $urandom}, 1'($urandom), w);
    end
    if_req_valid_i  = 1'b0;
    lsu_req_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_if_alone();
    test_lsu_store();
    test_contention();
    test_spurious();
    test_reset_mid();
    test_input_change();
    test_random(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
